// File: rtl/cga_scandoubler_pkg.sv
// cga_scandoubler_pkg: shared pixel/line-buffer constants and the output delay-line tap type.
package cga_scandoubler_pkg;
  localparam int PIX_W = 4;
  localparam int H_MAX = 1024;
  localparam int ADDR_W = 10;
  localparam int HSYNC_W = 56;
  localparam int MIN_LINE = 64;
  typedef logic [PIX_W-1:0] pix_t;
  typedef struct packed {
    logic blank;
    logic hs;
    logic vs;
    logic dbl;
  } tap_t;
endpackage

// File: rtl/cga_scandoubler_if.sv
// cga_scandoubler_if: CGA-rate input stream and doubled-rate output stream.
interface cga_scandoubler_if;
  import cga_scandoubler_pkg::*;
  logic in_ce;
  pix_t video_in;
  logic hsync_in;
  logic vsync_in;
  pix_t video_out;
  logic hsync_out;
  logic vsync_out;
  logic dbl_line;
  modport master(output in_ce, video_in, hsync_in, vsync_in, input video_out, hsync_out, vsync_out, dbl_line);
  modport slave(input in_ce, video_in, hsync_in, vsync_in, output video_out, hsync_out, vsync_out, dbl_line);
endinterface

// File: rtl/cga_scandoubler_linebuf.sv
// cga_linebuf: two-bank simple dual-port line RAM, registered read, no reset.
module cga_linebuf
  import cga_scandoubler_pkg::*;
(
  input  logic            clk,
  input  logic            we,
  input  logic [ADDR_W:0] wr_addr,
  input  pix_t            wr_data,
  input  logic [ADDR_W:0] rd_addr,
  output pix_t            rd_data
);
  pix_t mem [2*H_MAX];
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/cga_scandoubler.sv
// cga_scandoubler: ping-pong line buffer replaying each CGA input line twice at double rate.
module cga_scandoubler
  import cga_scandoubler_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  cga_scandoubler_if.slave   bus
);
  logic [ADDR_W-1:0] in_x, out_x;
  logic [ADDR_W:0] len;
  logic wr_bank, hs_prev, vs_s, dbl;
  logic [1:0] bank_valid;
  logic in_full, hs_edge, out_wrap;
  tap_t tap;
  pix_t rd_data;
  assign in_full = in_x == ADDR_W'(H_MAX-1);
  assign hs_edge = bus.in_ce && bus.hsync_in && !hs_prev && in_x >= ADDR_W'(MIN_LINE);
  assign out_wrap = {1'b0, out_x} == len - 1'b1;
  cga_linebuf u_buf (
    .clk(clk),
    .we(reset_n && bus.in_ce && !in_full),
    .wr_addr({wr_bank, in_x}),
    .wr_data(bus.video_in),
    .rd_addr({~wr_bank, out_x}),
    .rd_data(rd_data)
  );
  // A completed line flips the banks and restarts the reader in the same clk, so the
  // reader never lands on the bank being written.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_x <= '0;
      out_x <= '0;
      len <= (ADDR_W+1)'(H_MAX);
      wr_bank <= 1'b0;
      bank_valid <= '0;
      hs_prev <= 1'b0;
      vs_s <= 1'b0;
      dbl <= 1'b0;
      tap <= '{blank: 1'b1, hs: 1'b0, vs: 1'b0, dbl: 1'b0};
      bus.video_out <= '0;
      bus.hsync_out <= 1'b0;
      bus.vsync_out <= 1'b0;
      bus.dbl_line <= 1'b0;
    end else begin
      if (bus.in_ce) begin
        hs_prev <= bus.hsync_in;
        vs_s <= bus.vsync_in;
        if (!in_full) in_x <= in_x + 1'b1;
      end
      if (hs_edge) begin
        len <= {1'b0, in_x};
        in_x <= '0;
        bank_valid[wr_bank] <= 1'b1;
        wr_bank <= ~wr_bank;
        out_x <= '0;
        dbl <= 1'b0;
      end else begin
        out_x <= out_wrap ? '0 : out_x + 1'b1;
        dbl <= out_wrap ? ~dbl : dbl;
      end
      tap <= '{blank: !bank_valid[~wr_bank] || {1'b0, out_x} >= len,
               hs: out_x < ADDR_W'(HSYNC_W), vs: vs_s, dbl: dbl};
      bus.video_out <= tap.blank ? '0 : rd_data;
      bus.hsync_out <= tap.hs;
      bus.vsync_out <= tap.vs;
      bus.dbl_line <= tap.dbl;
    end
  end
endmodule

// File: tb/tb_cga_scandoubler.sv
// tb_cga_scandoubler: table of input lines replayed against per-clk expected doubled output.
module tb_cga_scandoubler;
  import cga_scandoubler_pkg::*;
  typedef struct {
    int len;
    bit vs;
    int glitch;
    int exp_l;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  cga_scandoubler_if bus();
  cga_scandoubler dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  vec_t vecs[12];
  int passed = 0;
  int total = 0;
  int k = 0;
  int cur_l = 1;
  int pend_l = 1;
  bit synced = 1'b0;
  bit prev_vs = 1'b0;
  bit cur_vs = 1'b0;

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s k=%0d got=%h exp=%h", name, k, got, exp);
  endtask

  task automatic cyc(input bit ce, input int v, input bit hs, input bit vs, input bit eg);
    int j, x, r;
    logic [6:0] got, exp;
    bus.in_ce = ce;
    bus.video_in = 4'(v);
    bus.hsync_in = hs;
    bus.vsync_in = vs;
    @(posedge clk);
    if (eg) begin
      k = 0;
      synced = 1'b1;
      cur_l = pend_l;
      prev_vs = vs;
    end else k++;
    @(negedge clk);
    got = {bus.video_out, bus.hsync_out, bus.vsync_out, bus.dbl_line};
    if (!reset_n) check("reset", got, 7'd0);
    else if (!synced) check("black", {bus.video_out, 3'b000}, 7'd0);
    else if (k >= 2) begin
      j = k - 2;
      x = j % cur_l;
      r = j / cur_l;
      exp = {4'(x % 15), x < HSYNC_W, (k >= 4) ? cur_vs : prev_vs, r[0]};
      check("line", got, exp);
    end
  endtask

  task automatic run_line(input vec_t t);
    cur_vs = t.vs;
    for (int d = 0; d < t.len; d++) begin
      cyc(1'b1, d % 15, d < 3 || d == t.glitch, t.vs, 1'b0);
      cyc(1'b0, d % 15, d < 3 || d == t.glitch, t.vs, 1'b0);
    end
    pend_l = t.exp_l;
    cyc(1'b1, 0, 1'b1, t.vs, 1'b1);
    cyc(1'b0, 0, 1'b1, t.vs, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{912, 1'b0, -1, 912};
    vecs[1]  = '{912, 1'b0, -1, 912};
    vecs[2]  = '{912, 1'b0, 20, 912};
    vecs[3]  = '{912, 1'b1, -1, 912};
    vecs[4]  = '{912, 1'b1, -1, 912};
    vecs[5]  = '{912, 1'b1, -1, 912};
    vecs[6]  = '{1200, 1'b0, -1, 1023};
    vecs[7]  = '{1020, 1'b0, -1, 1020};
    vecs[8]  = '{912, 1'b0, -1, 912};
    vecs[9]  = '{500, 1'b0, -1, 500};
    vecs[10] = '{300, 1'b0, -1, 300};
    vecs[11] = '{200, 1'b0, -1, 200};
    for (int i = 0; i < 4; i++) cyc(i[0] == 1'b0, 0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 9; i++) run_line(vecs[i]);
    cur_vs = 1'b0;
    for (int d = 0; d < 300; d++) begin
      cyc(1'b1, d % 15, d < 3, 1'b0, 1'b0);
      cyc(1'b0, d % 15, d < 3, 1'b0, 1'b0);
    end
    reset_n = 1'b0;
    synced = 1'b0;
    for (int i = 0; i < 5; i++) cyc(i[0] == 1'b0, 7, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    for (int i = 9; i < 12; i++) run_line(vecs[i]);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
